// File: rtl/apb_timer_if.sv
// APB slave bus bundle for the timer: select/enable/direction, address,
// write data and the registered read data returned by the slave.
interface apb_timer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/apb_timer.sv
// APB down-counting timer with 8-bit prescaler, one-shot/auto-reload modes,
// sticky underflow flag, protocol-error flag and a level interrupt.
// The bus access path is a two-state FSM: a setup cycle captures the access
// and, for reads, loads PRDATA; the following enable cycle commits writes.
module apb_timer (
  input  logic       HCLK,
  input  logic       HRESETn,
  apb_timer_if.slave apb,
  output logic       IRQ
);

  typedef enum logic [0:0] {
    A_IDLE  = 1'b0,
    A_SETUP = 1'b1
  } acc_state_e;

  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_LOAD     = 8'h04;
  localparam logic [7:0] OFS_VALUE    = 8'h08;
  localparam logic [7:0] OFS_PRESCALE = 8'h0C;
  localparam logic [7:0] OFS_STATUS   = 8'h10;

  // Access FSM and captured transfer
  acc_state_e  state_q;
  logic [7:0]  addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] prdata_q;

  // Programmer-visible registers and prescaler
  logic [2:0]  ctrl_q,     ctrl_d;      // {IRQEN, RELOAD, EN}
  logic [31:0] load_q,     load_d;
  logic [31:0] value_q,    value_d;
  logic [7:0]  prescale_q, prescale_d;
  logic        irqf_q,     irqf_d;
  logic        perr_q,     perr_d;
  logic [7:0]  pcnt_q,     pcnt_d;

  logic        setup_s;
  logic        commit_s;
  logic        abort_s;
  logic        wr_commit_s;
  logic        tick_s;
  logic        underflow_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  // Upper address bits are deliberately not decoded.
  assign unused_s    = ^apb.PADDR[31:8];

  assign setup_s     = apb.PSEL && !apb.PENABLE;
  assign commit_s    = (state_q == A_SETUP) && apb.PENABLE;
  assign abort_s     = (state_q == A_SETUP) && !apb.PENABLE;
  assign wr_commit_s = commit_s && write_q;

  assign tick_s      = ctrl_q[0] && (pcnt_q == prescale_q);
  assign underflow_s = tick_s && (value_q == 32'd0);

  assign apb.PRDATA  = prdata_q;
  assign IRQ         = irqf_q && ctrl_q[2];

  // Read mux on the live setup-cycle address; misaligned or unmapped reads give 0
  always_comb begin
    rd_data_s = 32'd0;
    case (apb.PADDR[7:0])
      OFS_CTRL:     rd_data_s = {29'd0, ctrl_q};
      OFS_LOAD:     rd_data_s = load_q;
      OFS_VALUE:    rd_data_s = value_q;
      OFS_PRESCALE: rd_data_s = {24'd0, prescale_q};
      OFS_STATUS:   rd_data_s = {30'd0, perr_q, irqf_q};
      default:      rd_data_s = 32'd0;
    endcase
  end

  // Register next-state: countdown, then bus writes which override hardware updates
  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    value_d    = value_q;
    prescale_d = prescale_q;
    irqf_d     = irqf_q;
    perr_d     = perr_q;
    pcnt_d     = pcnt_q;

    if (!ctrl_q[0]) begin
      pcnt_d = 8'd0;
    end else if (tick_s) begin
      pcnt_d = 8'd0;
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end

    if (tick_s && (value_q != 32'd0)) begin
      value_d = value_q - 32'd1;
    end else if (underflow_s && ctrl_q[1]) begin
      value_d = load_q;
    end else if (underflow_s) begin
      ctrl_d[0] = 1'b0;
    end else begin
      value_d = value_q;
    end

    // W1C first so a same-cycle hardware set still wins
    if (wr_commit_s && (addr_q == OFS_STATUS)) begin
      irqf_d = irqf_q & ~wdata_q[0];
      perr_d = perr_q & ~wdata_q[1];
    end else begin
      irqf_d = irqf_q;
      perr_d = perr_q;
    end

    if (underflow_s) begin
      irqf_d = 1'b1;
    end else begin
      irqf_d = irqf_d;
    end

    if (abort_s) begin
      perr_d = 1'b1;
    end else begin
      perr_d = perr_d;
    end

    if (wr_commit_s) begin
      case (addr_q)
        OFS_CTRL:     ctrl_d     = wdata_q[2:0];
        OFS_LOAD: begin
          load_d  = wdata_q;
          value_d = wdata_q;
        end
        OFS_PRESCALE: prescale_d = wdata_q[7:0];
        default:      ctrl_d     = ctrl_d;
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end
  end

  // Access FSM: capture on any setup cycle, return to idle after enable or abort
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= A_IDLE;
      addr_q   <= 8'd0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      prdata_q <= 32'd0;
    end else if (setup_s) begin
      state_q <= A_SETUP;
      addr_q  <= apb.PADDR[7:0];
      write_q <= apb.PWRITE;
      wdata_q <= apb.PWDATA;
      if (!apb.PWRITE) begin
        prdata_q <= rd_data_s;
      end else begin
        prdata_q <= prdata_q;
      end
    end else begin
      case (state_q)
        A_SETUP: state_q <= A_IDLE;
        A_IDLE:  state_q <= A_IDLE;
        default: state_q <= A_IDLE;
      endcase
    end
  end

  // Timer register state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q     <= 3'd0;
      load_q     <= 32'd0;
      value_q    <= 32'd0;
      prescale_q <= 8'd0;
      irqf_q     <= 1'b0;
      perr_q     <= 1'b0;
      pcnt_q     <= 8'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      value_q    <= value_d;
      prescale_q <= prescale_d;
      irqf_q     <= irqf_d;
      perr_q     <= perr_d;
      pcnt_q     <= pcnt_d;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: directed bus scenarios plus randomized
// timer runs predicted by a closed-form model of ticks since enable.
module tb_apb_timer;

  localparam logic [31:0] A_CTRL     = 32'h00;
  localparam logic [31:0] A_LOAD     = 32'h04;
  localparam logic [31:0] A_VALUE    = 32'h08;
  localparam logic [31:0] A_PRESCALE = 32'h0C;
  localparam logic [31:0] A_STATUS   = 32'h10;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic IRQ;
  int   tests_run = 0;
  int   tests_failed = 0;

  apb_timer_if bus ();

  apb_timer dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .apb     (bus),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Returns register contents as they stand when the task is called.
  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a; bus.PWDATA = 32'd0;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    d = bus.PRDATA;
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // k clock edges after the enabling CTRL write, (k / (P+1)) ticks have
  // occurred. One-shot: counts L..0, flags on tick L+1 and stops.
  // Reload: period of L+1 ticks, flag from tick L+1 on.
  function automatic void model(input int L, input int P, input bit reload, input int k,
                                output logic [31:0] v, output logic irqf, output logic en);
    int n;
    n = k / (P + 1);
    irqf = (n >= L + 1);
    if (reload) begin
      v  = 32'(L - (n % (L + 1)));
      en = 1'b1;
    end else begin
      v  = (n >= L) ? 32'd0 : 32'(L - n);
      en = (n < L + 1);
    end
  endfunction

  task automatic setup_timer(input int L, input int P, input logic [2:0] ctrl);
    apb_write(A_CTRL, 32'd0);
    apb_write(A_LOAD, 32'(L));
    apb_write(A_PRESCALE, 32'(P));
    apb_write(A_STATUS, 32'h3);
    apb_write(A_CTRL, {29'd0, ctrl});
  endtask

  task automatic run_probe(input string tag, input int L, input int P,
                           input logic [2:0] ctrl, input int k);
    logic [31:0] v;
    logic [31:0] d;
    logic        irqf;
    logic        en;
    setup_timer(L, P, ctrl);
    idle(k);
    model(L, P, ctrl[1], k, v, irqf, en);
    check({tag, " irq"}, {31'd0, IRQ}, {31'd0, irqf & ctrl[2]});
    apb_read(A_VALUE, d);
    check({tag, " value"}, d, v);
    model(L, P, ctrl[1], k + 2, v, irqf, en);
    apb_read(A_STATUS, d);
    check({tag, " status"}, d, {31'd0, irqf});
    model(L, P, ctrl[1], k + 4, v, irqf, en);
    apb_read(A_CTRL, d);
    check({tag, " ctrl"}, d, {29'd0, ctrl[2:1], en});
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] r;
    logic [31:0] w;
    int          L;
    int          P;
    int          k;
    logic [2:0]  c;

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 32'd0; bus.PWDATA = 32'd0;
    HRESETn = 1'b0;
    idle(2);
    check("rst prdata", bus.PRDATA, 32'd0);
    check("rst irq", {31'd0, IRQ}, 32'd0);
    HRESETn = 1'b1;
    idle(1);
    apb_read(A_CTRL, d);     check("rst ctrl", d, 32'd0);
    apb_read(A_LOAD, d);     check("rst load", d, 32'd0);
    apb_read(A_VALUE, d);    check("rst value", d, 32'd0);
    apb_read(A_PRESCALE, d); check("rst prescale", d, 32'd0);
    apb_read(A_STATUS, d);   check("rst status", d, 32'd0);

    // Write then read back
    apb_write(A_LOAD, 32'h0000_00FF);
    apb_read(A_LOAD, d);  check("wr load", d, 32'h0000_00FF);
    apb_read(A_VALUE, d); check("wr value", d, 32'h0000_00FF);
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      apb_write(A_LOAD, r);
      apb_read(A_LOAD, d); check("rnd load", d, r);
      r = $urandom;
      apb_write(A_PRESCALE, r);
      apb_read(A_PRESCALE, d); check("rnd prescale", d, {24'd0, r[7:0]});
      r = $urandom;
      apb_write(A_CTRL, r & 32'h6);
      apb_read(A_CTRL, d); check("rnd ctrl", d, r & 32'h6);
    end

    // Address decode
    apb_write(A_CTRL, 32'd0);
    apb_write(A_LOAD, 32'h0000_1234);
    apb_read(32'h14, d);          check("unmapped rd", d, 32'd0);
    apb_read(32'h05, d);          check("misalign rd", d, 32'd0);
    apb_write(32'h06, 32'hFFFF_FFFF);
    apb_write(32'h44, 32'hFFFF_FFFF);
    apb_read(32'h0000_0104, d);   check("upper addr rd", d, 32'h0000_1234);

    // One-shot countdown
    for (int i = 0; i < 6; i++) run_probe("oneshot", 3, 0, 3'h5, i);
    // Auto-reload with prescale
    run_probe("reload k0", 2, 3, 3'h3, 0);
    run_probe("reload k4", 2, 3, 3'h3, 4);
    run_probe("reload k8", 2, 3, 3'h3, 8);
    run_probe("reload k12", 2, 3, 3'h3, 12);
    run_probe("reload k7", 2, 3, 3'h3, 7);

    // Randomized runs
    for (int i = 0; i < 10; i++) begin
      L = int'($urandom_range(0, 5));
      P = int'($urandom_range(0, 3));
      c = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1};
      k = int'($urandom_range(0, (L + 3) * (P + 1)));
      run_probe("random", L, P, c, k);
    end

    // W1C of IRQF on the same edge as the underflow tick
    L = int'($urandom_range(1, 4));
    setup_timer(L, 0, 3'h5);
    idle(L - 1);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, d); check("w1c vs set", d, 32'h1);
    check("w1c vs set irq", {31'd0, IRQ}, 32'd1);
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, d); check("w1c clear", d, 32'h0);

    // LOAD write on the same edge as a tick
    setup_timer(100, 0, 3'h3);
    idle(int'($urandom_range(0, 5)));
    w = 32'($urandom_range(10, 5000));
    apb_write(A_LOAD, w);
    apb_read(A_VALUE, d); check("load vs tick", d, w);
    apb_read(A_VALUE, d); check("load then count", d, w - 32'd2);

    // Setup abandoned with PSEL low
    apb_write(A_CTRL, 32'd0);
    apb_write(A_LOAD, 32'h0000_1234);
    apb_write(A_STATUS, 32'h3);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = A_LOAD; bus.PWDATA = 32'hDEAD_0000;
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0;
    @(posedge HCLK); #1;
    apb_read(A_LOAD, d);   check("perr no write", d, 32'h0000_1234);
    apb_read(A_STATUS, d); check("perr status", d, 32'h2);
    apb_write(A_STATUS, 32'h2);
    apb_read(A_STATUS, d); check("perr cleared", d, 32'h0);

    // Setup followed directly by a new setup
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = A_LOAD; bus.PWDATA = 32'hBEEF_0000;
    @(posedge HCLK); #1;
    apb_write(A_PRESCALE, 32'h0000_005A);
    apb_read(A_LOAD, d);     check("resetup no write", d, 32'h0000_1234);
    apb_read(A_PRESCALE, d); check("resetup new", d, 32'h0000_005A);
    apb_read(A_STATUS, d);   check("resetup perr", d, 32'h2);
    apb_write(A_STATUS, 32'h2);

    // Enable without setup is ignored
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = A_LOAD; bus.PWDATA = 32'h0BAD_0BAD;
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    apb_read(A_LOAD, d);   check("idle enable", d, 32'h0000_1234);
    apb_read(A_STATUS, d); check("idle enable perr", d, 32'h0);

    // Reset during the access phase of a CTRL write while counting
    setup_timer(1, 0, 3'h7);
    idle(3);
    check("pre-reset irq", {31'd0, IRQ}, 32'd1);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = A_CTRL; bus.PWDATA = 32'h7;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    #2 HRESETn = 1'b0;
    #1;
    check("mid rst irq", {31'd0, IRQ}, 32'd0);
    check("mid rst prdata", bus.PRDATA, 32'd0);
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    idle(1);
    HRESETn = 1'b1;
    idle(1);
    apb_read(A_CTRL, d);     check("post rst ctrl", d, 32'd0);
    apb_read(A_LOAD, d);     check("post rst load", d, 32'd0);
    apb_read(A_VALUE, d);    check("post rst value", d, 32'd0);
    apb_read(A_PRESCALE, d); check("post rst prescale", d, 32'd0);
    apb_read(A_STATUS, d);   check("post rst status", d, 32'd0);
    check("post rst irq", {31'd0, IRQ}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
